// File: rtl/bcnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcnn_pkg
// Purpose  : Shared types and constants for the binary conv cell datapath.
//            Holds the activation-packer state enum, the Q8.8 fractional bit
//            count and the default accumulator width.
// Revision : 1.0 - initial release
// ============================================================================
package bcnn_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } act_state_t;

    // Fractional bits of the Q8.8 conv result and of the accumulator.
    localparam int Q_FRAC    = 8;

    // Default accumulator width: signed Q(ACC_W-8).8.
    localparam int ACC_W_DEF = 20;

endpackage : bcnn_pkg
`default_nettype wire

// File: rtl/bin_acc_add.sv
`default_nettype none
// ============================================================================
// Module   : bin_acc_add
// Purpose  : Signed ACC_W accumulator adder with a 16-bit sign-extended
//            Q8.8 operand. Behaviour on overflow is selected at build time:
//              BIN_ACT_SATURATE_EN defined   -> clamp to the signed range
//              BIN_ACT_SATURATE_EN undefined -> wrap modulo 2^ACC_W
// Ports    : acc_i  - current accumulator (signed, ACC_W)
//            data_i - conv result (signed Q8.8, 16 bits)
//            sum_o  - acc_i + sext(data_i) (signed, ACC_W)
// Revision : 1.0 - initial release
// ============================================================================
module bin_acc_add
    import bcnn_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [15:0]      data_i,
    output logic signed [ACC_W-1:0] sum_o
);

`ifdef BIN_ACT_SATURATE_EN
    // One guard bit makes overflow visible as a mismatch of the top two bits.
    logic signed [ACC_W:0] w_full;

    always_comb begin
        w_full = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-16){data_i[15]}}, data_i};
        if (w_full[ACC_W] != w_full[ACC_W-1]) begin
            // Guard bit carries the true sign of the result.
            sum_o = w_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum_o = w_full[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        sum_o = acc_i + {{(ACC_W-16){data_i[15]}}, data_i};
    end
`endif

endmodule : bin_acc_add
`default_nettype wire

// File: rtl/bin_act_pack.sv
`default_nettype none
// ============================================================================
// Module   : bin_act_pack
// Purpose  : Accumulates C_IN signed Q8.8 conv results per output pixel,
//            applies a folded batch-norm threshold and sign binarisation,
//            and packs PACK_W pixel bits (first pixel in bit 0) into a word
//            offered over a valid/ready handshake. A flush pulse emits a
//            partial word. Overflow handling follows BIN_ACT_SATURATE_EN
//            (see bin_acc_add).
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready/in_data - conv result stream (Q8.8)
//            thr/thr_inv               - threshold and comparison invert
//            flush                     - emit the partially packed word
//            out_valid/out_ready       - packed word handshake
//            out_word/out_nbits        - packed bits and count of valid bits
// Revision : 1.0 - initial release
// ============================================================================
module bin_act_pack
    import bcnn_pkg::*;
#(
    parameter int C_IN   = 4,
    parameter int PACK_W = 8,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0]                 in_data,
    input  logic [ACC_W-1:0]            thr,
    input  logic                        thr_inv,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PACK_W-1:0]           out_word,
    output logic [$clog2(PACK_W+1)-1:0] out_nbits
);

    localparam int CH_W = (C_IN > 1) ? $clog2(C_IN) : 1;
    localparam int NB_W = $clog2(PACK_W + 1);

    act_state_t               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
    logic [PACK_W-1:0]        pack_q, pack_d;
    logic [NB_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PACK_W-1:0]        out_word_q, out_word_d;
    logic [NB_W-1:0]          out_nbits_q, out_nbits_d;

    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_new_bit;
    logic [PACK_W-1:0]        w_pack_new;

    bin_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (acc_q),
        .data_i (in_data),
        .sum_o  (w_sum)
    );

    // Sign binarisation against the folded BN threshold; a negative gamma
    // flips the comparison direction.
    assign w_new_bit  = ($signed(w_sum) >= $signed(thr)) ^ thr_inv;
    assign w_pack_new = pack_q | (PACK_W'(w_new_bit) << bit_cnt_q);

    assign in_ready  = (state_q == ACCUM) && !flush;
    assign out_valid = (state_q == EMIT);
    assign out_word  = out_word_q;
    assign out_nbits = out_nbits_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ch_cnt_d    = ch_cnt_q;
        pack_d      = pack_q;
        bit_cnt_d   = bit_cnt_q;
        out_word_d  = out_word_q;
        out_nbits_d = out_nbits_q;

        unique case (state_q)
            ACCUM: begin
                if (flush) begin
                    // Any partially accumulated pixel is dropped; pack_q is
                    // already zero above bit_cnt_q, so no explicit padding.
                    acc_d    = '0;
                    ch_cnt_d = '0;
                    if (bit_cnt_q != '0) begin
                        out_word_d  = pack_q;
                        out_nbits_d = bit_cnt_q;
                        pack_d      = '0;
                        bit_cnt_d   = '0;
                        state_d     = EMIT;
                    end
                end else if (in_valid) begin
                    if (ch_cnt_q == CH_W'(C_IN - 1)) begin
                        acc_d    = '0;
                        ch_cnt_d = '0;
                        if (bit_cnt_q == NB_W'(PACK_W - 1)) begin
                            out_word_d  = w_pack_new;
                            out_nbits_d = NB_W'(PACK_W);
                            pack_d      = '0;
                            bit_cnt_d   = '0;
                            state_d     = EMIT;
                        end else begin
                            pack_d    = w_pack_new;
                            bit_cnt_d = bit_cnt_q + NB_W'(1);
                        end
                    end else begin
                        acc_d    = w_sum;
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            pack_q      <= '0;
            bit_cnt_q   <= '0;
            out_word_q  <= '0;
            out_nbits_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            pack_q      <= pack_d;
            bit_cnt_q   <= bit_cnt_d;
            out_word_q  <= out_word_d;
            out_nbits_q <= out_nbits_d;
        end
    end

endmodule : bin_act_pack
`default_nettype wire

// File: tb/tb_bin_act_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_act_pack
// Purpose  : Self-checking bench for bin_act_pack. Two instances share one
//            stimulus stream: one with the default 20-bit accumulator and one
//            with a 17-bit accumulator to reach the overflow corner. A
//            transaction-level reference model predicts handshake signals and
//            packed words each cycle. Honours BIN_ACT_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_act_pack;

    localparam int C_IN   = 4;
    localparam int PACK_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    int          thr_val = 0;
    logic        thr_inv = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        rnd_ready = 1'b0;

    logic [19:0] thr_a;
    logic [16:0] thr_b;
    assign thr_a = thr_val[19:0];
    assign thr_b = thr_val[16:0];

    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [7:0]  out_word_a, out_word_b;
    logic [3:0]  out_nbits_a, out_nbits_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bin_act_pack #(.C_IN(C_IN), .PACK_W(PACK_W), .ACC_W(20)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .thr(thr_a), .thr_inv(thr_inv), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_word(out_word_a), .out_nbits(out_nbits_a)
    );

    bin_act_pack #(.C_IN(C_IN), .PACK_W(PACK_W), .ACC_W(17)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .thr(thr_b), .thr_inv(thr_inv), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_word(out_word_b), .out_nbits(out_nbits_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int d, input string s);
        return {(d == 0) ? "a_" : "b_", s};
    endfunction

    // Accumulator add of a given width, wrapping or clamping like the design.
    function automatic longint add_m(input longint a, input longint x, input int w);
        longint s, lo, hi, m;
        s  = a + x;
        lo = -(64'sd1 <<< (w - 1));
        hi = (64'sd1 <<< (w - 1)) - 1;
`ifdef BIN_ACT_SATURATE_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        m = (64'sd1 <<< w) - 1;
        s = s & m;
        if (s > hi) s = s - (64'sd1 <<< w);
`endif
        return s;
    endfunction

    // ---------------- reference model ----------------
    int     acc_w_m[2] = '{20, 17};
    longint m_acc[2];
    int     m_ch[2], m_pack[2], m_bits[2], m_word[2], m_nb[2];
    bit     m_emit[2];

    initial begin
        longint s;
        int     b;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    check(tg(d, "rst_valid"), (d == 0) ? out_valid_a : out_valid_b, 0);
                    check(tg(d, "rst_word"),  (d == 0) ? out_word_a  : out_word_b, 0);
                    check(tg(d, "rst_nbits"), (d == 0) ? out_nbits_a : out_nbits_b, 0);
                    m_acc[d] = 0; m_ch[d] = 0; m_pack[d] = 0; m_bits[d] = 0;
                    m_word[d] = 0; m_nb[d] = 0; m_emit[d] = 0;
                end else begin
                    check(tg(d, "in_ready"),  (d == 0) ? in_ready_a  : in_ready_b,
                          (!m_emit[d] && !flush) ? 1 : 0);
                    check(tg(d, "out_valid"), (d == 0) ? out_valid_a : out_valid_b, m_emit[d] ? 1 : 0);
                    check(tg(d, "out_word"),  (d == 0) ? out_word_a  : out_word_b, m_word[d]);
                    check(tg(d, "out_nbits"), (d == 0) ? out_nbits_a : out_nbits_b, m_nb[d]);
                    if (m_emit[d]) begin
                        if (out_ready) m_emit[d] = 0;
                    end else if (flush) begin
                        m_acc[d] = 0;
                        m_ch[d]  = 0;
                        if (m_bits[d] > 0) begin
                            m_word[d] = m_pack[d]; m_nb[d] = m_bits[d]; m_emit[d] = 1;
                            m_pack[d] = 0; m_bits[d] = 0;
                        end
                    end else if (in_valid) begin
                        s = add_m(m_acc[d], longint'($signed(in_data)), acc_w_m[d]);
                        if (m_ch[d] == C_IN - 1) begin
                            b = ((s >= longint'(thr_val)) ? 1 : 0) ^ int'(thr_inv);
                            m_pack[d] = m_pack[d] | (b << m_bits[d]);
                            m_bits[d]++;
                            m_acc[d] = 0;
                            m_ch[d]  = 0;
                            if (m_bits[d] == PACK_W) begin
                                m_word[d] = m_pack[d]; m_nb[d] = PACK_W; m_emit[d] = 1;
                                m_pack[d] = 0; m_bits[d] = 0;
                            end
                        end else begin
                            m_acc[d] = s;
                            m_ch[d]++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic beat(input logic [15:0] data);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        in_valid = 1'b1;
        in_data  = data;
        while (!acc && n < 60) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pixel whose sum is +0x180 (bit 1 at thr 0x100) or -0x100 (bit 0).
    task automatic pixel(input bit hi);
        beat(16'h0100);
        beat(16'h0100);
        beat(16'hFF00);
        beat(hi ? 16'h0080 : 16'hFE00);
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = out_valid_a;
            n++;
        end
        if (!ok) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        bit         ok;
        logic [7:0] held;
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [7:0] held;

        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Alternating pixels 1,0,... -> 0x55.
        thr_val = 32'h100;
        thr_inv = 1'b0;
        for (int i = 0; i < PACK_W; i++) pixel(i % 2 == 0);
        wait_valid(ok);
        check("alt_word", out_word_a, 8'h55);
        check("alt_nbits", out_nbits_a, 8);
        idle(2);

        // Backpressure: hold the word for five cycles.
        out_ready = 1'b0;
        for (int i = 0; i < PACK_W; i++) pixel(i < 4);
        wait_valid(ok);
        held = out_word_a;
        check("bp_word", held, 8'h0F);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_word", out_word_a, held);
            check("bp_in_ready", in_ready_a, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", out_valid_a, 1);
        @(negedge clk);
        check("bp_released", out_valid_a, 0);
        idle(1);

        // Flush of a partial word 1,0,1.
        pixel(1); pixel(0); pixel(1);
        do_flush();
        wait_valid(ok);
        check("flush_word", out_word_a, 8'h05);
        check("flush_nbits", out_nbits_a, 3);
        idle(2);

        // Flush with two channels pending and nothing packed: no output.
        beat(16'h0100);
        beat(16'h0100);
        do_flush();
        repeat (3) begin
            @(negedge clk);
            check("empty_flush_valid", out_valid_a, 0);
        end
        // Next pixel starts clean: 0x80*4 = 0x200 >= 0x100 -> 1; invert -> 0.
        thr_inv = 1'b1;
        repeat (4) beat(16'h0080);
        thr_inv = 1'b0;
        pixel(1);
        do_flush();
        wait_valid(ok);
        check("inv_clean_word", out_word_a, 8'h02);
        check("inv_clean_nbits", out_nbits_a, 2);
        idle(2);

        // Overflow corner on the 17-bit accumulator.
        thr_val = 0;
        repeat (4) beat(16'h7FFF);
        do_flush();
        wait_valid(ok);
`ifdef BIN_ACT_SATURATE_EN
        check("ovf_b_bit", out_word_b, 8'h01);
`else
        check("ovf_b_bit", out_word_b, 8'h00);
`endif
        check("ovf_a_bit", out_word_a, 8'h01);
        idle(2);

        // Reset after two of four channels.
        thr_val = 32'h100;
        pixel(1);
        beat(16'h0100);
        beat(16'h0100);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < PACK_W; i++) pixel(i == 1 || i == 6);
        wait_valid(ok);
        check("post_rst_word", out_word_a, 8'h42);
        idle(2);

        // Randomised traffic; the model checks every cycle.
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            thr_val = int'($urandom_range(0, 3072)) - 1536;
            thr_inv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                out_ready = 1'($urandom_range(0, 1));
                do_flush();
            end else if ($urandom_range(0, 9) == 0) begin
                beat(16'($urandom));
            end else begin
                beat(16'(int'($urandom_range(0, 1536)) - 768));
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_bin_act_pack
`default_nettype wire

// File: doc/bin_act_pack.md
# bin_act_pack

Downstream stage of the binary conv cell. Accumulates the cell's signed Q8.8 partial sums across `C_IN` input channels, applies a folded batch-norm threshold and sign binarisation, and packs `PACK_W` consecutive output-pixel bits into one word. It presents the packed word to the next layer's input buffer over a valid/ready handshake.

## Interface
Parameters:
- `C_IN`, 4: conv results accumulated per output pixel (≥1)
- `PACK_W`, 8: activation bits per output word (≥1)
- `ACC_W`, 20: accumulator width, signed Q(ACC_W-8).8, ≥16

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  conv result present
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_data`  in  16  signed Q8.8 conv result
- `thr`  in  ACC_W  signed threshold, same format as accumulator
- `thr_inv`  in  1  invert comparison (negative BN gamma)
- `flush`  in  1  one-cycle pulse: emit partial word
- `out_valid`  out  1  packed word available
- `out_ready`  in  1  consumer accepts word
- `out_word`  out  PACK_W  packed activations, first pixel in bit 0
- `out_nbits`  out  $clog2(PACK_W+1)  valid bits in `out_word`

## Operation
- States: `ACCUM`, `EMIT`. Reset state `ACCUM`.
- `in_ready = (state==ACCUM) & !flush` (combinational).
- Accepted beat: `acc <= acc + sext(in_data)`; `ch_cnt` increments.
- Beat with `ch_cnt==C_IN-1`: sum `s = acc + sext(in_data)`; `bit = (s >= thr) ^ thr_inv` (signed compare, `thr` sampled that cycle); bit stored at `pack[bit_cnt]`; `acc`, `ch_cnt` cleared; `bit_cnt` increments.
- When the stored bit makes `bit_cnt==PACK_W`: `out_word <= pack` incl. new bit, `out_nbits <= PACK_W`, go `EMIT`; `pack`, `bit_cnt` cleared.
- `flush` in `ACCUM`: partial accumulation (`acc`, `ch_cnt`) discarded. If `bit_cnt>0`: `out_word <= pack` zero-padded above `bit_cnt`, `out_nbits <= bit_cnt`, go `EMIT`. If `bit_cnt==0`: no output. `flush` in `EMIT` ignored.
- `EMIT`: `out_valid=1`; `out_word`/`out_nbits` stable until `out_valid & out_ready`, then return to `ACCUM`.
- `flush` and `in_valid` same cycle: flush wins; beat not accepted.
- Accumulation overflow: see Configuration.

## Timing
- Reset values: `out_valid=0`, `out_word=0`, `out_nbits=0`, `acc=0`, all counters 0. `in_ready=1` after reset deasserts.
- Latency: `out_valid` rises the cycle after the handshake of the final channel of the `PACK_W`-th pixel, or the cycle after `flush`.
- `in_ready` is 0 for every `EMIT` cycle. Minimum one bubble cycle per word.
- With `out_ready` held high: `EMIT` lasts 1 cycle.
- Reset mid-operation clears all partial state immediately. No output results from the aborted pixel.

## Configuration
- `BIN_ACT_SATURATE_EN` defined: accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Undefined: add wraps modulo 2^ACC_W.
- Both variants use identical ports and timing.

## Structure
- Shared package `bcnn_pkg`:
  - state enum `act_state_t {ACCUM, EMIT}`
  - Q8.8 fractional-bit constant `Q_FRAC=8`
  - default `ACC_W`
- One sub-module: `bin_acc_add`. Signed ACC_W adder plus 16-bit sign-extended operand, with saturation selected by `BIN_ACT_SATURATE_EN`.

## Test plan
- Pixel math: C_IN=4, thr=0x00100, thr_inv=0, beats 0x0100,0x0100,0xFF00,0x0080 (sum 0x180) -> bit 1. Same with last beat 0xFE00 (sum -0x100) -> bit 0. Eight pixels alternating 1,0 -> `out_word=0x55`, `out_nbits=8`.
- Backpressure: `out_ready=0` for 5 cycles after `out_valid` -> `out_valid`, `out_word` held stable, `in_ready=0`. Word transfers on the cycle `out_ready` rises.
- Overflow: ACC_W=17, C_IN=4, four 0x7FFF beats, thr=0, thr_inv=0:
  - with `BIN_ACT_SATURATE_EN`: acc clamps to 0x0FFFF -> bit 1
  - without: acc wraps to -4 -> bit 0
- Flush: pixel bits 1,0,1 then `flush` -> `out_word=0x05`, `out_nbits=3`. `flush` with 2 channels pending and `bit_cnt=0` -> no `out_valid`, next pixel starts clean.
- Invert: thr_inv=1, sum 0x180 vs thr 0x100 -> bit 0.
- Reset mid-pixel: `rst_n` low after 2 of 4 channels -> all outputs at reset values. Next 8 full pixels produce a correct word.
